// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding and ALU operand forwarding select codes.
package mips_pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // EX_MEM holds the younger result, so it is checked before MEM_WB.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic       ex_mem_regwrite,
    input logic [4:0] ex_mem_rd,
    input logic       mem_wb_regwrite,
    input logic [4:0] mem_wb_rd
  );
    if (ex_mem_regwrite && ex_mem_rd != 5'd0 && ex_mem_rd == src) begin
      return FWD_EXMEM;
    end
    if (mem_wb_regwrite && mem_wb_rd != 5'd0 && mem_wb_rd == src) begin
      return FWD_MEMWB;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational EX-stage operand forwarding selects for ALU operands A (rs) and B (rt).
module forwarding_unit
  import mips_pipe_pkg::*;
(
  input  logic       ex_mem_regwrite,
  input  logic [4:0] ex_mem_rd,
  input  logic       mem_wb_regwrite,
  input  logic [4:0] mem_wb_rd,
  input  logic [4:0] id_ex_rs,
  input  logic [4:0] id_ex_rt,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_select(id_ex_rs, ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd);
  assign fwd_b = fwd_select(id_ex_rt, ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: memory-wait freeze FSM, load-use stall, branch flush,
// saturating stall counter and forwarding selects. Control outputs are zero-latency.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             branch_taken,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rs,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mem_regwrite,
  input  logic [4:0]       ex_mem_rd,
  input  logic             mem_wb_regwrite,
  input  logic [4:0]       mem_wb_rd,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int              WC_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       timeout_hit, freeze, load_use;

  forwarding_unit u_fwd (
    .ex_mem_regwrite (ex_mem_regwrite),
    .ex_mem_rd       (ex_mem_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .id_ex_rs        (id_ex_rs),
    .id_ex_rt        (id_ex_rt),
    .fwd_a           (fwd_a_raw),
    .fwd_b           (fwd_b_raw)
  );

  // A timed-out wait releases the pipe in the same cycle, overriding the freeze.
  assign timeout_hit = (state_q == MEM_WAIT) && !dmem_ready && (wait_cnt_q == WAIT_LAST);
  assign freeze      = ((state_q == MEM_WAIT) || dmem_req) && !dmem_ready && !timeout_hit;
  assign load_use    = id_ex_memread && (id_ex_rt != 5'd0) &&
                       ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;

    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b1;
    mem_wb_bubble = 1'b0;
    forward_a     = fwd_a_raw;
    forward_b     = fwd_b_raw;

    if (freeze) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (load_use) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          if (timeout_hit) begin
            mem_timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    if (!reset_in) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      ex_mem_we     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
      forward_a     = FWD_REG;
      forward_b     = FWD_REG;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 4;
  localparam int STALL_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_in;
  logic [4:0]       id_rs, id_rt, id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd;
  logic             branch_taken, id_ex_memread, ex_mem_regwrite, mem_wb_regwrite;
  logic             dmem_req, dmem_ready;
  logic             pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble;
  logic [1:0]       forward_a, forward_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_in        (reset_in),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .branch_taken    (branch_taken),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rs        (id_ex_rs),
    .id_ex_rt        (id_ex_rt),
    .ex_mem_regwrite (ex_mem_regwrite),
    .ex_mem_rd       (ex_mem_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_we           (pc_we),
    .if_id_we        (if_id_we),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_we       (ex_mem_we),
    .mem_wb_bubble   (mem_wb_bubble),
    .forward_a       (forward_a),
    .forward_b       (forward_b),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  typedef struct packed {
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_we;
    logic             mem_wb_bubble;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             tmo;
    logic [CNT_W-1:0] stalls;
  } outs_t;

  // Model state: are we inside a memory wait episode, how many frozen cycles it has had.
  bit m_waiting = 1'b0;
  int m_frozen  = 0;
  int m_stalls  = 0;
  bit m_tmo     = 1'b0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (ex_mem_regwrite && ex_mem_rd == src) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_timeout_now();
    return m_waiting && !dmem_ready && (m_frozen == MEM_TIMEOUT - 1);
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    bit frz, lu, br;
    frz = (m_waiting || dmem_req) && !dmem_ready && !ref_timeout_now();
    lu  = !frz && id_ex_memread && id_ex_rt != 5'd0 && (id_ex_rt == id_rs || id_ex_rt == id_rt);
    br  = !frz && !lu && branch_taken;
    o.pc_we         = !(frz || lu);
    o.if_id_we      = !(frz || lu);
    o.if_id_flush   = br;
    o.id_ex_bubble  = lu;
    o.ex_mem_we     = !frz;
    o.mem_wb_bubble = frz;
    o.fa            = ref_fwd(id_ex_rs);
    o.fb            = ref_fwd(id_ex_rt);
    o.tmo           = m_tmo;
    o.stalls        = CNT_W'(m_stalls);
    if (!reset_in) begin
      o = '0;
      o.if_id_flush   = 1'b1;
      o.id_ex_bubble  = 1'b1;
      o.mem_wb_bubble = 1'b1;
    end
    return o;
  endfunction

  outs_t u_o;
  bit    u_hit;
  always @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      m_waiting = 1'b0;
      m_frozen  = 0;
      m_stalls  = 0;
      m_tmo     = 1'b0;
    end else begin
      u_o   = model_outs();
      u_hit = ref_timeout_now();
      if (!u_o.pc_we && m_stalls < STALL_MAX) m_stalls = m_stalls + 1;
      if (!u_o.ex_mem_we) begin
        m_waiting = 1'b1;
        m_frozen  = m_frozen + 1;
      end else begin
        if (u_hit) m_tmo = 1'b1;
        m_waiting = 1'b0;
        m_frozen  = 0;
      end
    end
  end

  outs_t cmp_e, cmp_a;
  always @(negedge clk) begin
    cmp_e = model_outs();
    cmp_a = {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble,
             forward_a, forward_b, mem_timeout, stall_cycles};
    tests++;
    if (cmp_a !== cmp_e) begin
      fails++;
      $display("FAIL model_cmp t=%0t got %h expected %h", $time, cmp_a, cmp_e);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_ex_rs = 0; id_ex_rt = 0; ex_mem_rd = 0; mem_wb_rd = 0;
    branch_taken = 0; id_ex_memread = 0; ex_mem_regwrite = 0; mem_wb_regwrite = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  int n;
  bit released;

  initial begin
    clear_inputs();
    reset_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc_we", 32'(pc_we), 0);
    check("rst_flush", 32'(if_id_flush), 1);
    check("rst_mwb_bubble", 32'(mem_wb_bubble), 1);
    step();
    reset_in = 1'b1;

    // forwarding priority
    ex_mem_rd = 7; mem_wb_rd = 7; ex_mem_regwrite = 1; mem_wb_regwrite = 1;
    id_ex_rs = 7; id_ex_rt = 7;
    @(negedge clk);
    check("fwd_a_exmem", 32'(forward_a), 32'b10);
    check("fwd_b_exmem", 32'(forward_b), 32'b10);
    step();
    ex_mem_regwrite = 0;
    @(negedge clk);
    check("fwd_a_memwb", 32'(forward_a), 32'b01);
    step();
    ex_mem_regwrite = 1; ex_mem_rd = 0; mem_wb_rd = 0;
    @(negedge clk);
    check("fwd_a_r0", 32'(forward_a), 32'b00);

    // load-use
    step();
    clear_inputs();
    id_ex_memread = 1; id_ex_rt = 5; id_rs = 5;
    @(negedge clk);
    check("lu_pc_we", 32'(pc_we), 0);
    check("lu_bubble", 32'(id_ex_bubble), 1);
    check("lu_ex_mem_we", 32'(ex_mem_we), 1);
    step();
    id_ex_memread = 0;
    @(negedge clk);
    check("lu_one_cycle", 32'(pc_we), 1);
    step();
    id_ex_memread = 1; id_ex_rt = 0; id_rs = 0;
    @(negedge clk);
    check("lu_r0_no_stall", 32'(pc_we), 1);

    // branch vs load-use
    step();
    id_ex_memread = 1; id_ex_rt = 3; id_rt = 3; branch_taken = 1;
    @(negedge clk);
    check("br_lu_flush", 32'(if_id_flush), 0);
    check("br_lu_pc_we", 32'(pc_we), 0);
    step();
    id_ex_memread = 0;
    @(negedge clk);
    check("br_flush", 32'(if_id_flush), 1);
    check("br_pc_we", 32'(pc_we), 1);

    // async reset in the middle of a memory wait
    step();
    clear_inputs();
    dmem_req = 1;
    step();
    step();
    @(negedge clk);
    #2 reset_in = 1'b0;
    #1;
    check("arst_pc_we", 32'(pc_we), 0);
    check("arst_ex_mem_we", 32'(ex_mem_we), 0);
    check("arst_flush", 32'(if_id_flush), 1);
    check("arst_bubble", 32'(id_ex_bubble), 1);
    check("arst_stalls", 32'(stall_cycles), 0);
    step();
    reset_in = 1'b1;
    dmem_req = 0;
    @(negedge clk);
    check("arst_state_run", 32'(pc_we), 1);

    // 3-cycle memory access
    step();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mem3_freeze", 32'(pc_we), 0);
      step();
    end
    dmem_ready = 1;
    @(negedge clk);
    check("mem3_release", 32'(pc_we), 1);
    step();
    dmem_req = 0; dmem_ready = 0;
    @(negedge clk);
    check("mem3_stalls", 32'(stall_cycles), 3);

    // memory never ready: forced release on the 16th cycle
    check("tmo_clear", 32'(mem_timeout), 0);
    step();
    dmem_req = 1; dmem_ready = 0;
    n = 0;
    released = 1'b0;
    while (!released && n < 40) begin
      @(negedge clk);
      n++;
      if (pc_we) released = 1'b1;
    end
    check("tmo_release_cycle", 32'(n), 16);
    step();
    dmem_req = 0;
    @(negedge clk);
    check("tmo_set", 32'(mem_timeout), 1);
    check("stall_saturated", 32'(stall_cycles), STALL_MAX);
    step();
    step();
    @(negedge clk);
    check("tmo_sticky", 32'(mem_timeout), 1);

    // randomized traffic; ready becomes rare in the second half to provoke timeouts
    for (int i = 0; i < 3000; i++) begin
      step();
      reset_in        = ($urandom_range(0, 299) != 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_ex_rs        = 5'($urandom_range(0, 3));
      id_ex_rt        = 5'($urandom_range(0, 3));
      ex_mem_rd       = 5'($urandom_range(0, 3));
      mem_wb_rd       = 5'($urandom_range(0, 3));
      branch_taken    = ($urandom_range(0, 3) == 0);
      id_ex_memread   = ($urandom_range(0, 2) == 0);
      ex_mem_regwrite = ($urandom_range(0, 1) == 0);
      mem_wb_regwrite = ($urandom_range(0, 1) == 0);
      dmem_req        = ($urandom_range(0, 9) < 3);
      dmem_ready      = ($urandom_range(0, 9) < ((i < 1500) ? 4 : 1));
    end
    step();
    reset_in = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got no finish expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
